hex_scan_ctrl: RTL

Sequencing controller that shares one BCD-to-seven-segment decoder across four HEX displays (HEX0..HEX3). A host presents a 4-digit BCD word with a one-cycle load strobe. The controller captures the word, then time-multiplexes the decoder over the digits, one per cycle, into per-display output registers. It sits between switch/counter logic and the board's HEX pins, and can optionally re-scan periodically.

---
 rtl/hex_scan_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl
//   Shares one BCD-to-seven-segment decoder across four HEX displays. A
//   one-cycle load captures a 4-digit BCD word; the controller then writes
//   one display per cycle (HEX0 first, HEX3 last) and pulses done. With
//   REFRESH_CYCLES != 0 the held word is re-scanned after that many idle
//   cycles.
//
//   Optional build macro: HEX_LZB_EN -- leading-zero blanking of HEX3..HEX1.
//
//   Ports:
//     clk              system clock, rising edge
//     rst              synchronous active-high reset
//     load             one-cycle capture/scan request (ignored unless idle)
//     value[15:0]      BCD word, [3:0] -> HEX0 ... [15:12] -> HEX3
//     HEX0..HEX3[0:6]  segments a..g, active-low, registered
//     busy             high while scanning
//     done             one-cycle pulse after HEX3 is written

// Single shared decoder: digit -> active-low segments a..g.
module hex_seg_dec (
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [0:6] seg
);
   always_comb begin
      seg = 7'b1111111;
      if (!blank) begin
         case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001101;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
         endcase
      end
   end
endmodule

module hex_scan_ctrl #(
   parameter int unsigned REFRESH_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value,
   output logic [0:6]  HEX0,
   output logic [0:6]  HEX1,
   output logic [0:6]  HEX2,
   output logic [0:6]  HEX3,
   output logic        busy,
   output logic        done
);
   localparam int unsigned CW        = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int unsigned RC_LAST_I = (REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1;
   localparam logic [CW-1:0] RC_LAST = RC_LAST_I[CW-1:0];

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state, state_nx;
   logic [15:0]     hold;
   logic [1:0]      idx;
   logic [CW-1:0]   rcnt;
   logic [3:0][0:6] hex_q;
   logic [3:0]      lzb;
   logic [3:0]      digit;
   logic [0:6]      seg;
   logic            auto_hit;

`ifdef HEX_LZB_EN
   // Digit k blanks when it and every higher digit are zero; HEX0 never blanks.
   assign lzb[3] = (hold[15:12] == 4'd0);
   assign lzb[2] = lzb[3] && (hold[11:8] == 4'd0);
   assign lzb[1] = lzb[2] && (hold[7:4]  == 4'd0);
   assign lzb[0] = 1'b0;
`else
   assign lzb = 4'b0000;
`endif

   assign digit = hold[{idx, 2'b00} +: 4];

   hex_seg_dec u_dec (
      .digit (digit),
      .blank (lzb[idx]),
      .seg   (seg)
   );

   // Auto re-scan trigger; load wins over it in the same idle cycle.
   assign auto_hit = (REFRESH_CYCLES != 0) && (rcnt == RC_LAST);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load || auto_hit) state_nx = SCAN;
         SCAN:    if (idx == 2'd3)      state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hold  <= 16'h0000;
         idx   <= 2'd0;
         rcnt  <= '0;
         hex_q <= '1;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (load) hold <= value;
               if (state_nx == SCAN) begin
                  idx  <= 2'd0;
                  rcnt <= '0;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            SCAN: begin
               // Only the addressed display is written; the rest hold.
               hex_q[idx] <= seg;
               idx        <= idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == SCAN);
   assign done = (state == DONE);
   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
endmodule
